nor_seq_ctrl: RTL

NOR_SEQ_CTRL -- requirements
Module: nor_seq_ctrl

---
 rtl/nor_seq_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/nor_seq_ctrl.sv
// Sequential normalizer for a signed block-floating accumulator sum:
// converts to sign/magnitude, then left-shifts by 4 or 1 per cycle until normalized.
module nor_seq_ctrl #(
  parameter int SUM_W = 20,
  parameter int EXP_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] signed_sum_in,
  input  logic [EXP_W-1:0] exp_max_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [SUM_W-1:0] mant_out,
  output logic [EXP_W-1:0] exp_out,
  output logic             zero_out,
  output logic             uflow_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [SUM_W-1:0] mag, mag_n;
  logic [EXP_W-1:0] exp_r, exp_n;
  logic             sgn, sgn_n;

  logic             load;
  logic [SUM_W-1:0] mant_n;
  logic [EXP_W-1:0] exp_o_n;
  logic             sign_n, zero_n, uflow_n;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    mag_n   = mag;
    exp_n   = exp_r;
    sgn_n   = sgn;
    load    = 1'b0;
    mant_n  = '0;
    exp_o_n = '0;
    sign_n  = 1'b0;
    zero_n  = 1'b0;
    uflow_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sgn_n   = signed_sum_in[SUM_W-1];
          mag_n   = signed_sum_in[SUM_W-1] ? (~signed_sum_in + 1'b1)
                                           : signed_sum_in;
          exp_n   = exp_max_in;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (mag == '0) begin
          load    = 1'b1;
          zero_n  = 1'b1;
          state_n = DONE;
        end else if (mag[SUM_W-1]) begin
          load    = 1'b1;
          mant_n  = mag;
          exp_o_n = exp_r;
          sign_n  = sgn;
          state_n = DONE;
        end else if (exp_r == '0) begin
          // exponent exhausted: emit the partially shifted magnitude
          load    = 1'b1;
          mant_n  = mag;
          sign_n  = sgn;
          uflow_n = 1'b1;
          state_n = DONE;
        end else if (mag[SUM_W-1-:4] == 4'd0 && exp_r >= EXP_W'(4)) begin
          mag_n = mag << 4;
          exp_n = exp_r - EXP_W'(4);
        end else begin
          mag_n = mag << 1;
          exp_n = exp_r - EXP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag       <= '0;
      exp_r     <= '0;
      sgn       <= 1'b0;
      sign_out  <= 1'b0;
      mant_out  <= '0;
      exp_out   <= '0;
      zero_out  <= 1'b0;
      uflow_out <= 1'b0;
    end else begin
      mag   <= mag_n;
      exp_r <= exp_n;
      sgn   <= sgn_n;
      if (load) begin
        sign_out  <= sign_n;
        mant_out  <= mant_n;
        exp_out   <= exp_o_n;
        zero_out  <= zero_n;
        uflow_out <= uflow_n;
      end
    end
  end

endmodule
